// File: rtl/reg_fifo_if.sv
// Producer/consumer handshake bundle for reg_fifo: write side (din/wr_en/full/almost_full)
// and read side (dout/rd_en/empty). The fifo uses the slave modport, the neighbours use master.
interface reg_fifo_if #(
    parameter int WIDTH = 128
);
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             full;
    logic             almost_full;
    logic [WIDTH-1:0] dout;
    logic             rd_en;
    logic             empty;

    modport master (
        output din, wr_en, rd_en,
        input  full, almost_full, dout, empty
    );

    modport slave (
        input  din, wr_en, rd_en,
        output full, almost_full, dout, empty
    );
endinterface

// File: rtl/reg_fifo.sv
// DEPTH-word first-word-fall-through register fifo: output stage plus a DEPTH-1 word array.
// Optional feature macro REG_FIFO_COUNT_EN adds a registered occupancy output "count".
module reg_fifo #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef REG_FIFO_COUNT_EN
    output logic [$clog2(DEPTH+1)-1:0]   count,
`endif
    reg_fifo_if.slave                    bus
);
    localparam int ARR_D = DEPTH - 1;
    localparam int PTR_W = (ARR_D > 1) ? $clog2(ARR_D) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam ptr_t PTR_LAST = ptr_t'(ARR_D - 1);
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam logic AF_RST   = (DEPTH <= AF_MARGIN);

    logic [WIDTH-1:0] mem_q [ARR_D];

    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    cnt_t             cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             full_q, full_d;
    logic             af_q, af_d;
    logic             empty_q, empty_d;

    logic             wr_acc, rd_acc, arr_has, bypass, mem_we;

    // Wrap by explicit compare so non-power-of-2 array depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_LAST) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        wr_acc      = bus.wr_en & ~full_q;
        rd_acc      = bus.rd_en & ~empty_q;
        arr_has     = (cnt_q != cnt_t'(out_valid_q));

        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        bypass      = 1'b0;

        if (!out_valid_q || rd_acc) begin
            if (arr_has) begin
                dout_d      = mem_q[rd_ptr_q];
                rd_ptr_d    = ptr_inc(rd_ptr_q);
                out_valid_d = 1'b1;
            end else if (wr_acc) begin
                dout_d      = bus.din;
                bypass      = 1'b1;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        mem_we = wr_acc & ~bypass;
        if (mem_we) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_t'(cnt_q + 1'b1);
            2'b01:   cnt_d = cnt_t'(cnt_q - 1'b1);
            default: cnt_d = cnt_q;
        endcase

        full_d  = (cnt_d == CNT_FULL);
        af_d    = ((DEPTH - int'(cnt_d)) <= AF_MARGIN);
        empty_d = ~out_valid_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together
    // from the values computed above.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            full_q      <= 1'b0;
            af_q        <= AF_RST;
            empty_q     <= 1'b1;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            full_q      <= full_d;
            af_q        <= af_d;
            empty_q     <= empty_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; cnt and the pointers decide
    // which entries are meaningful, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.empty       = empty_q;

`ifdef REG_FIFO_COUNT_EN
    assign count = cnt_q;
`endif
endmodule
